// File: rtl/alu_fpga_if.sv
// Bundle of the ALU's operand, control and result signals, so that board-level
// logic and benches can carry them as a single connection.
interface alu_fpga_if #(
    parameter int WIDTH = 32,
    parameter int IN_W  = 4
);
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic [1:0]       shamt;
    logic [3:0]       funct;
    logic [WIDTH-1:0] out;

    modport master (output a, b, shamt, funct, input out);
    modport slave  (input a, b, shamt, funct, output out);
endinterface

// File: rtl/alu_fpga.sv
// Board wrapper: zero-extends 4-bit switch operands, runs them through a 32-bit
// ALU (adder/subtractor, logic unit, barrel shifter) and registers the result.
module alu_fpga #(
    parameter int WIDTH = 32,
    parameter int IN_W  = 4
) (
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [1:0]       shamt,
    input  logic [3:0]       funct,
    input  logic             clk,
    output logic [WIDTH-1:0] out,
    input  logic             rst_n
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SLA = 4'd6,
        OP_SRA = 4'd7,
        OP_SRL = 4'd8
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             fill;
    logic [WIDTH-1:0] shl1;
    logic [WIDTH-1:0] shl2;
    logic [WIDTH-1:0] shr1;
    logic [WIDTH-1:0] shr2;
    logic [WIDTH-1:0] result;

    assign op  = op_e'(funct);
    assign opa = {{(WIDTH-IN_W){1'b0}}, a};
    assign opb = {{(WIDTH-IN_W){1'b0}}, b};

    // One adder serves both ADD and SUB: A - B = A + ~B + 1.
    assign sub = (op == OP_SUB);
    assign sum = opa + (sub ? ~opb : opb) + {{(WIDTH-1){1'b0}}, sub};

    // Two-stage barrel shifter (by 1, then by 2); right shifts fill with A[31] for SRA.
    assign fill = (op == OP_SRA) & opa[WIDTH-1];
    assign shl1 = shamt[0] ? {opa[WIDTH-2:0], 1'b0}        : opa;
    assign shl2 = shamt[1] ? {shl1[WIDTH-3:0], 2'b00}      : shl1;
    assign shr1 = shamt[0] ? {fill, opa[WIDTH-1:1]}        : opa;
    assign shr2 = shamt[1] ? {{2{fill}}, shr1[WIDTH-1:2]}  : shr1;

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves result unassigned (no latch).
        result = '0;
        case (op)
            OP_ADD, OP_SUB: result = sum;
            OP_AND:         result = opa & opb;
            OP_OR:          result = opa | opb;
            OP_XOR:         result = opa ^ opb;
            OP_NOT:         result = ~opa;
            OP_SLA:         result = shl2;
            OP_SRA, OP_SRL: result = shr2;
            default:        result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment for registered state avoids simulation races between flops.
        if (!rst_n) out <= '0;
        else        out <= result;
    end

endmodule

// File: tb/tb_alu_fpga.sv
// Self-checking bench for alu_fpga: directed test-plan vectors plus random
// vectors, checked through a scoreboard queue one cycle after each drive.
module tb_alu_fpga;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          failures;
    logic [31:0] exp_q[$];

    alu_fpga_if #(.WIDTH(32), .IN_W(4)) bus ();

    alu_fpga #(.WIDTH(32), .IN_W(4)) dut (
        .a     (bus.a),
        .b     (bus.b),
        .shamt (bus.shamt),
        .funct (bus.funct),
        .clk   (clk),
        .out   (bus.out),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] f, input logic [3:0] ia,
                                          input logic [3:0] ib, input logic [1:0] s);
        logic [31:0] x, y;
        x = {28'd0, ia};
        y = {28'd0, ib};
        case (f)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return x ^ y;
            4'd5:    return ~x;
            4'd6:    return x << s;
            4'd7:    return $unsigned($signed(x) >>> s);
            4'd8:    return x >> s;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_in(input logic [3:0] f, input logic [3:0] ia,
                          input logic [3:0] ib, input logic [1:0] s);
        bus.funct = f;
        bus.a     = ia;
        bus.b     = ib;
        bus.shamt = s;
    endtask

    // Drive at the falling edge, push the expectation, compare #1 after the capturing edge.
    task automatic run(input string tag, input logic [3:0] f, input logic [3:0] ia,
                       input logic [3:0] ib, input logic [1:0] s, input logic [31:0] exp);
        @(negedge clk);
        set_in(f, ia, ib, s);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check({tag, "_queue_empty"}, 32'd1, 32'd0);
        else                   check(tag, bus.out, exp_q.pop_front());
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_in(4'd0, 4'd12, 4'd3, 2'd0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", bus.out, 32'd0);

        // Release, capture 15, then assert reset mid-cycle and expect an immediate clear.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture", bus.out, 32'd15);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.out, 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold", bus.out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("released_before_edge", bus.out, 32'd0);
        @(posedge clk);
        #1;
        check("release_capture", bus.out, 32'd15);

        run("add",        4'd0, 4'd12, 4'd3,  2'd0, 32'd15);
        run("sub",        4'd1, 4'd12, 4'd3,  2'd0, 32'd9);
        run("sub_neg",    4'd1, 4'd3,  4'd12, 2'd0, 32'hFFFF_FFF7);
        run("add_max",    4'd0, 4'd15, 4'd15, 2'd0, 32'd30);
        run("and",        4'd2, 4'd12, 4'd3,  2'd0, 32'd0);
        run("or",         4'd3, 4'd12, 4'd3,  2'd0, 32'd15);
        run("xor",        4'd4, 4'd12, 4'd3,  2'd0, 32'd15);
        run("not",        4'd5, 4'd12, 4'd3,  2'd0, 32'hFFFF_FFF3);
        run("sla_0",      4'd6, 4'd12, 4'd3,  2'd0, 32'd12);
        run("sla_3",      4'd6, 4'd12, 4'd3,  2'd3, 32'd96);
        run("sla_1",      4'd6, 4'd15, 4'd0,  2'd1, 32'd30);
        run("sra_2",      4'd7, 4'd12, 4'd3,  2'd2, 32'd3);
        run("srl_2",      4'd8, 4'd12, 4'd3,  2'd2, 32'd3);
        run("srl_3",      4'd8, 4'd12, 4'd3,  2'd3, 32'd1);
        run("srl_1",      4'd8, 4'd13, 4'd3,  2'd1, 32'd6);
        run("undef_9",    4'd9, 4'd12, 4'd3,  2'd0, 32'd0);
        run("undef_15",   4'd15, 4'd12, 4'd3, 2'd0, 32'd0);

        // Latency: output must hold the ADD result until the edge after the switch to SUB.
        run("lat_add",    4'd0, 4'd12, 4'd3,  2'd0, 32'd15);
        @(negedge clk);
        set_in(4'd1, 4'd12, 4'd3, 2'd0);
        #2;
        check("lat_hold", bus.out, 32'd15);
        @(posedge clk);
        #1;
        check("lat_sub", bus.out, 32'd9);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] f, ia, ib;
            logic [1:0] s;
            f  = 4'($urandom_range(0, 15));
            ia = 4'($urandom_range(0, 15));
            ib = 4'($urandom_range(0, 15));
            s  = 2'($urandom_range(0, 3));
            run($sformatf("rand_%0d_f%0d", i, f), f, ia, ib, s, model(f, ia, ib, s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_fpga.md
Name: alu_fpga

Overview:
- Board-level wrapper around a 32-bit combinational ALU, driven from 4-bit switch inputs.
- Zero-extends the 4-bit operands `a` and `b` to 32 bits and applies the operation selected by `funct`.
- Shift operations use the 2-bit `shamt`.
- The 32-bit result is registered on the clock and drives board outputs (LEDs/display logic downstream).

Parameters:
- WIDTH, 32, datapath and result width.
- IN_W, 4, width of the operand inputs `a` and `b`.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  4  operand A, unsigned, zero-extended to WIDTH.
- b  input  4  operand B, unsigned, zero-extended to WIDTH.
- shamt  input  2  shift amount, 0..3.
- funct  input  4  operation select.
- out  output  32  registered result, interpreted as signed two's complement.
- Positional declaration order is fixed: a, b, shamt, funct, clk, out, rst_n. Existing positional instantiations rely on the first six.

Behaviour:
- Operand extension:
  - A = {28'b0, a}, B = {28'b0, b}.
  - All arithmetic is done at 32 bits, modulo 2^32.
- funct encoding (result R):
  - 0 ADD: R = A + B.
  - 1 SUB: R = A - B, two's complement; a negative result wraps into the signed 32-bit range.
  - 2 AND: R = A & B.
  - 3 OR: R = A | B.
  - 4 XOR: R = A ^ B.
  - 5 NOT: R = ~A, bitwise over all 32 bits; `b` is ignored.
  - 6 SLA: R = A << shamt, zero fill.
  - 7 SRA: R = A >>> shamt, sign bit A[31] replicated. A[31] is always 0 after zero-extension, so this equals SRL for in-range inputs.
  - 8 SRL: R = A >> shamt, zero fill.
  - 9..15: R = 0.
- Shift rules:
  - Shifts operate on A only; `b` is ignored.
  - Shift count is `shamt` only (0..3); shamt = 0 passes A through unchanged.
- Timing:
  - R is combinational from a, b, shamt, funct.
  - out <= R on every rising clk edge, giving 1-cycle latency.
  - No enable and no handshake; out updates every cycle.
- Reset:
  - rst_n low asynchronously forces out = 0 immediately, regardless of clk.
  - While rst_n is low, out holds 0.
  - First capture occurs on the first rising edge after rst_n deasserts.
  - Reset asserted mid-operation discards the pending result.
- Unknown inputs: before a, b or funct are driven, out may be X; no requirement applies.
- No overflow or carry flag outputs. ADD cannot overflow with 4-bit operands (maximum 30).
- Internal structure:
  - Separate adder/subtractor (shared adder with B inversion and carry-in for SUB).
  - Logic unit.
  - Barrel shifter handling logical and arithmetic right shift and left shift.
  - Output mux, then the output register.

Test Plan:
- Reset: rst_n = 0 mid-cycle with funct = ADD, a = 12, b = 3 -> out = 0 immediately; release rst_n -> out = 15 after next rising edge.
- Arithmetic, a = 12, b = 3:
  - ADD -> 15.
  - SUB -> 9.
  - SUB with a = 3, b = 12 -> -9 (0xFFFFFFF7).
  - ADD with a = 15, b = 15 -> 30.
- Logic, a = 12, b = 3: AND -> 0; OR -> 15; XOR -> 15; NOT -> -13 (0xFFFFFFF3).
- Shifts, a = 12:
  - SLA shamt = 0 -> 12; SLA shamt = 3 -> 96.
  - SRA shamt = 2 -> 3.
  - SRL shamt = 2 -> 3; SRL shamt = 3 -> 1.
- Latency: change funct from ADD to SUB between edges -> out stays 15 until the next rising edge, then 9.
- Undefined codes: funct = 9 and funct = 15 with a = 12, b = 3 -> out = 0 after the next edge.
